// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 18-bit CPU: fetch, decode and sequence
// FETCH/DECODE/EXEC/MEM/WB, driving ALU selects, write strobes and memory.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [17:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic             rs1_zero,
    output logic [17:0]      ir,
    output logic [1:0]       mux2_select,
    output logic             mux1_select,
    output logic             reg_write,
    output logic             reg_wsel,
    output logic             pc_write,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        opcode;
    logic              is_ld, is_st, is_jmp, is_bz, is_hlt, is_bad;
    logic [1:0]        alu_op;
    logic              alu_b;

    assign opcode = ir[17:14];
    assign is_ld  = (opcode == 4'h6);
    assign is_st  = (opcode == 4'h7);
    assign is_jmp = (opcode == 4'h8);
    assign is_bz  = (opcode == 4'h9);
    assign is_hlt = (opcode == 4'hf);
    assign is_bad = (opcode >= 4'ha) && (opcode <= 4'he);
    assign state  = st;
    assign halted = (st == HALT);

    always_comb begin
        alu_op = 2'b00;
        alu_b  = 1'b0;
        case (opcode)
            4'h1: alu_b = 1'b1;
            4'h2: alu_op = 2'b01;
            4'h3: begin
                alu_op = 2'b01;
                alu_b  = 1'b1;
            end
            4'h4: alu_op = 2'b10;
            4'h5: alu_op = 2'b11;
            4'h6, 4'h7: alu_b = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mux2_select  = 2'b00;
        mux1_select  = 1'b0;
        reg_write    = 1'b0;
        reg_wsel     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        case (st)
            FETCH: begin
                mem_req  = 1'b1;
                pc_write = mem_ready;
            end
            EXEC: begin
                mux2_select = alu_op;
                mux1_select = alu_b;
                pc_write    = is_jmp | (is_bz & rs1_zero);
                pc_src      = is_jmp | is_bz;
            end
            MEM: begin
                mux2_select  = alu_op;
                mux1_select  = alu_b;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_st;
            end
            WB: begin
                mux2_select = alu_op;
                mux1_select = alu_b;
                reg_write   = 1'b1;
                reg_wsel    = is_ld;
            end
            default: ;
        endcase
    end

    // Both request states share the ready/timeout race: ready wins on the timeout cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= FETCH;
            ir          <= '0;
            instr_count <= '0;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            case (st)
                FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        wait_cnt <= '0;
                        st       <= DECODE;
                    end else if (wait_cnt == TMO) begin
                        bus_error <= 1'b1;
                        st        <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    if (is_hlt) begin
                        instr_count <= instr_count + 1'b1;
                        st          <= HALT;
                    end else if (is_bad) begin
                        illegal <= 1'b1;
                        st      <= HALT;
                    end else begin
                        st <= EXEC;
                    end
                end
                EXEC: begin
                    wait_cnt <= '0;
                    if (is_ld || is_st) begin
                        st <= MEM;
                    end else if (is_jmp || is_bz) begin
                        instr_count <= instr_count + 1'b1;
                        st          <= FETCH;
                    end else begin
                        st <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (is_ld) begin
                            st <= WB;
                        end else begin
                            instr_count <= instr_count + 1'b1;
                            st          <= FETCH;
                        end
                    end else if (wait_cnt == TMO) begin
                        bus_error <= 1'b1;
                        st        <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB: begin
                    instr_count <= instr_count + 1'b1;
                    wait_cnt    <= '0;
                    st          <= FETCH;
                end
                default: st <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: reactive memory responder,
// per-instruction reference model, and an independent monitor.
module tb_multicycle_control;

    localparam int CNT_W = 16;

    typedef struct {
        logic [17:0] instr;
        int          fw;
        int          mw;
        bit          rz;
    } stim_t;

    typedef struct {
        int             cyc;
        int             rw;
        bit             wsel;
        int             we;
        int             pw;
        bit             chk_sel;
        logic [1:0]     m2;
        bit             m1;
        logic [CNT_W-1:0] cnt;
        bit             halted;
        bit             ill;
        bit             berr;
    } exp_t;

    logic             clk = 0;
    logic             rst = 1;
    logic [17:0]      mem_rdata = '0;
    logic             mem_ready = 0;
    logic             rs1_zero = 0;
    logic [17:0]      ir;
    logic [1:0]       mux2_select;
    logic             mux1_select;
    logic             reg_write, reg_wsel, pc_write, pc_src;
    logic             mem_req, mem_we, mem_addr_sel;
    logic [2:0]       state;
    logic             halted, illegal, bus_error;
    logic [CNT_W-1:0] instr_count;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rs1_zero(rs1_zero), .ir(ir), .mux2_select(mux2_select),
        .mux1_select(mux1_select), .reg_write(reg_write), .reg_wsel(reg_wsel),
        .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .state(state),
        .halted(halted), .illegal(illegal), .bus_error(bus_error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    stim_t stim_q[$];
    exp_t  sb_q[$];
    bit    resp_en = 0;
    bit    mon_en  = 0;
    logic [CNT_W-1:0] exp_cnt;

    task automatic check(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: whole-instruction outcome from the ISA rules
    function automatic exp_t model(stim_t s, logic [CNT_W-1:0] cnt_in);
        exp_t e;
        int op;
        e = '{cyc:0, rw:0, wsel:0, we:0, pw:0, chk_sel:0, m2:2'b00, m1:0,
              cnt:cnt_in, halted:0, ill:0, berr:0};
        op = int'(s.instr[17:14]);
        if (s.fw > 15) begin
            e.cyc = 16; e.berr = 1; e.halted = 1;
            return e;
        end
        e.cyc = s.fw + 2;
        e.pw = 1;
        if (op == 15) begin
            e.cnt = cnt_in + 1; e.halted = 1;
            return e;
        end
        if (op >= 10) begin
            e.ill = 1; e.halted = 1;
            return e;
        end
        e.cyc += 1;
        case (op)
            0: begin e.m2 = 2'b00; e.m1 = 0; end
            1: begin e.m2 = 2'b00; e.m1 = 1; end
            2: begin e.m2 = 2'b01; e.m1 = 0; end
            3: begin e.m2 = 2'b01; e.m1 = 1; end
            4: begin e.m2 = 2'b10; e.m1 = 0; end
            5: begin e.m2 = 2'b11; e.m1 = 0; end
            6, 7: begin e.m2 = 2'b00; e.m1 = 1; end
            default: ;
        endcase
        e.chk_sel = (op <= 7);
        if (op == 8 || op == 9) begin
            if (op == 8 || s.rz) e.pw += 1;
            e.cnt = cnt_in + 1;
            return e;
        end
        if (op == 6 || op == 7) begin
            if (s.mw > 15) begin
                e.cyc += 16; e.berr = 1; e.halted = 1;
                if (op == 7) e.we = 16;
                return e;
            end
            e.cyc += s.mw + 1;
            if (op == 7) begin
                e.we = s.mw + 1;
                e.cnt = cnt_in + 1;
                return e;
            end
        end
        e.cyc += 1;
        e.rw = 1;
        e.wsel = (op == 6);
        e.cnt = cnt_in + 1;
        return e;
    endfunction

    task automatic add(logic [17:0] ins, int fw, int mw, bit rz);
        stim_t s;
        exp_t e;
        s = '{instr:ins, fw:fw, mw:mw, rz:rz};
        stim_q.push_back(s);
        e = model(s, exp_cnt);
        exp_cnt = e.cnt;
        sb_q.push_back(e);
    endtask

    // Memory responder: picks up a new stimulus at each FETCH entry
    initial begin : responder
        stim_t cur;
        bit have;
        int wcnt;
        logic [2:0] rprev;
        have = 0; wcnt = 0; rprev = 3'd7;
        cur = '{instr:'0, fw:0, mw:0, rz:0};
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                mem_ready = 0;
                rprev = 3'd7;
                have = 0;
            end else begin
                if (state == 3'd0 && rprev != 3'd0) begin
                    have = (stim_q.size() != 0);
                    if (have) cur = stim_q.pop_front();
                    wcnt = 0;
                    mem_rdata = cur.instr;
                    rs1_zero = cur.rz;
                end
                rprev = state;
                if (mem_req && have) begin
                    mem_ready = (wcnt == ((state == 3'd0) ? cur.fw : cur.mw));
                    if (mem_ready) wcnt = 0;
                    else wcnt++;
                end else begin
                    mem_ready = 0;
                end
            end
        end
    end

    // Monitor: one record per instruction, closed at next FETCH or HALT entry
    initial begin : monitor
        bit in_rec;
        logic [2:0] mprev;
        int a_cyc, a_rw, a_we, a_pw;
        bit a_wsel, a_pcs_ok, a_addr_ok, a_m1;
        logic [1:0] a_m2;
        exp_t e;
        in_rec = 0; mprev = 3'd7;
        a_cyc = 0; a_rw = 0; a_we = 0; a_pw = 0;
        a_wsel = 0; a_pcs_ok = 1; a_addr_ok = 1; a_m1 = 0; a_m2 = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_rec = 0;
                mprev = 3'd7;
            end else begin
                if ((state == 3'd0 && mprev != 3'd0) ||
                    (state == 3'd5 && mprev != 3'd5)) begin
                    if (in_rec) begin
                        if (sb_q.size() == 0) begin
                            check("sb_unexpected_instr", 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            check("cycles", a_cyc, e.cyc);
                            check("reg_write_pulses", a_rw, e.rw);
                            if (e.rw != 0) check("reg_wsel", a_wsel, e.wsel);
                            check("mem_we_cycles", a_we, e.we);
                            check("pc_write_pulses", a_pw, e.pw);
                            check("pc_src", a_pcs_ok, 1);
                            check("mem_addr_sel", a_addr_ok, 1);
                            if (e.chk_sel) begin
                                check("mux2_select", a_m2, e.m2);
                                check("mux1_select", a_m1, e.m1);
                            end
                            check("instr_count", instr_count, e.cnt);
                            check("halted", halted, e.halted);
                            check("illegal", illegal, e.ill);
                            check("bus_error", bus_error, e.berr);
                        end
                    end
                    in_rec = (state == 3'd0);
                    a_cyc = 0; a_rw = 0; a_we = 0; a_pw = 0;
                    a_wsel = 0; a_pcs_ok = 1; a_addr_ok = 1; a_m1 = 0; a_m2 = 0;
                end
                if (in_rec) begin
                    a_cyc++;
                    if (reg_write) begin
                        a_rw++;
                        a_wsel = reg_wsel;
                    end
                    if (mem_req && mem_we) a_we++;
                    if (pc_write) begin
                        a_pw++;
                        if (pc_src != (state == 3'd2)) a_pcs_ok = 0;
                    end
                    if (mem_req && mem_addr_sel != (state == 3'd3)) a_addr_ok = 0;
                    if (state == 3'd2) begin
                        a_m2 = mux2_select;
                        a_m1 = mux1_select;
                    end
                end
                mprev = state;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; resp_en = 0; mon_en = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        stim_q.delete();
        sb_q.delete();
        exp_cnt = '0;
        check("rst_state", state, 0);
        check("rst_mem_req", mem_req, 1);
        check("rst_ir", ir, 0);
        check("rst_instr_count", instr_count, 0);
        check("rst_flags", {illegal, bus_error, halted}, 0);
        check("rst_strobes", {reg_write, pc_write, mem_we, mem_addr_sel}, 0);
        resp_en = 1; mon_en = 1;
    endtask

    task automatic drain(int budget);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic halt_quiet();
        int bad;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || mem_we || reg_write || pc_write || !halted) bad++;
        end
        check("halt_quiet", bad, 0);
    endtask

    initial begin : main
        int op;
        int i;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int op;
        int i;
        exp_cnt = '0;
        do_reset();
        add(18'h04405, 0, 0, 0);
        add(18'h18843, 2, 2, 0);
        add(18'h24000, 0, 0, 0);
        add(18'h24000, 1, 0, 1);
        add(18'h20003, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 9);
            add({op[3:0], 14'($urandom)}, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom));
        end
        add(18'h3c000, 0, 0, 0);
        drain(3000);
        halt_quiet();

        do_reset();
        add(18'h28000, 0, 0, 0);
        drain(100);
        halt_quiet();
        check("illegal_sticky", illegal, 1);

        do_reset();
        add(18'h04405, 16, 0, 0);
        drain(100);
        halt_quiet();
        check("bus_error_sticky", bus_error, 1);

        do_reset();
        add(18'h04405, 15, 0, 0);
        add(18'h3c000, 0, 0, 0);
        drain(200);

        do_reset();
        add(18'h18843, 0, 20, 0);
        drain(200);

        do_reset();
        add(18'h04405, 0, 0, 0);
        stim_q.push_back('{instr:18'h1c843, fw:0, mw:10, rz:0});
        i = 0;
        while (!(state == 3'd3 && sb_q.size() == 0) && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        check("st_reached_mem", state, 3);
        repeat (2) begin @(posedge clk); #1; end
        check("st_mem_we_pending", {mem_req, mem_we}, 3);
        rst = 1; mon_en = 0; resp_en = 0;
        @(posedge clk); #1;
        rst = 0;
        check("abort_state", state, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_instr_count", instr_count, 0);
        check("abort_mem_req", mem_req, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
